fully_assoc_cache_ctrl: RTL and testbench

FULLY_ASSOC_CACHE_CTRL -- requirements
Module: fully_assoc_cache_ctrl

---
 rtl/fa_cache_pkg.sv | 24 ++
 rtl/fully_assoc_cache_ctrl_if.sv | 30 +++
 rtl/fa_cache_victim_sel.sv | 28 ++
 rtl/fully_assoc_cache_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_fully_assoc_cache_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fa_cache_pkg.sv
// Shared definitions for the fully associative cache controller.
// Holds the controller state encoding and helpers that derive the
// word-offset and tag widths from the address and line geometry.
package fa_cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HIT_RESP,
      MISS_REQ,
      REFILL,
      MISS_RESP
   } state_t;

   // Width of the word-offset field (address bits [off_w+1:2]).
   function automatic int calc_off_w(input int words);
      return $clog2(words);
   endfunction

   // Width of the tag: everything above the offset and byte-lane bits.
   function automatic int calc_tag_w(input int addr_w, input int words);
      return addr_w - $clog2(words) - 2;
   endfunction

endpackage

// File: rtl/fully_assoc_cache_ctrl_if.sv
// Bundle of the request/response and memory-refill signals of the
// fully associative cache controller.
//   master : requester + memory model side (drives requests and refill beats)
//   slave  : controller side
interface fully_assoc_cache_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              resp_valid;
   logic              resp_hit;
   logic [DATA_W-1:0] resp_data;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_data;

   modport master (
      output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
      input  req_ready, resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr
   );

   modport slave (
      input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
      output req_ready, resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr
   );
endinterface

// File: rtl/fa_cache_victim_sel.sv
// Victim selection for the fully associative cache.
// Ports:
//   valid         : per-line valid bits
//   ptr           : round-robin replacement pointer
//   victim        : line to refill (lowest invalid line, else ptr)
//   replace_valid : 1 when the chosen victim currently holds a valid line
module fa_cache_victim_sel #(
   parameter int LINES = 16
) (
   input  logic [LINES-1:0]         valid,
   input  logic [$clog2(LINES)-1:0] ptr,
   output logic [$clog2(LINES)-1:0] victim,
   output logic                     replace_valid
);
   localparam int IDX_W = $clog2(LINES);

   // Scan from the top down so the lowest invalid index wins.
   always_comb begin
      victim        = ptr;
      replace_valid = 1'b1;
      for (int i = LINES - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            victim        = IDX_W'(i);
            replace_valid = 1'b0;
         end
      end
   end
endmodule

// File: rtl/fully_assoc_cache_ctrl.sv
// Fully associative, read-only cache controller.
// Lookup compares the request tag against every valid line in the accept
// cycle; hits respond one cycle later, misses fetch a full line from memory
// (WORDS ascending beats) into a victim line and then respond.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : invalidate all lines (acted on in IDLE only)
//   req_valid/ready/addr  : lookup request handshake
//   resp_valid/hit/data   : one-cycle response strobe, hit flag, word
//   mem_req_valid/ready/addr : line fetch request to memory
//   mem_resp_valid/data   : refill beats
module fully_assoc_cache_ctrl
   import fa_cache_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int LINES  = 16,
   parameter int WORDS  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [DATA_W-1:0] resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data
);
   localparam int OFF_W  = calc_off_w(WORDS);
   localparam int TAG_W  = calc_tag_w(ADDR_W, WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int LINE_W = WORDS * DATA_W;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

   state_t             state_reg;
   logic [LINES-1:0]   valid_reg;
   logic [IDX_W-1:0]   ptr_reg;
   logic [IDX_W-1:0]   victim_reg;
   logic               repl_reg;
   logic [OFF_W-1:0]   beat_reg;
   logic [OFF_W-1:0]   off_reg;
   logic [TAG_W-1:0]   tag_reg;
   logic [DATA_W-1:0]  word_reg;
   logic               ready_reg;

   logic [TAG_W-1:0]   tag_arr  [LINES];
   logic [LINE_W-1:0]  data_arr [LINES];

   logic [TAG_W-1:0]   req_tag;
   logic [OFF_W-1:0]   req_off;
   logic [LINES-1:0]   hit_vec;
   logic               any_hit;
   logic [IDX_W-1:0]   hit_idx;
   logic [LINE_W-1:0]  hit_line;
   logic [DATA_W-1:0]  hit_word;
   logic [IDX_W-1:0]   victim_idx;
   logic               victim_repl;
   logic               accept;
   logic               unused_lane;

   assign req_tag     = req_addr[ADDR_W-1 -: TAG_W];
   assign req_off     = req_addr[OFF_W+1:2];
   assign unused_lane = ^req_addr[1:0];

   // ready_reg is low only during reset and in the first cycle after it,
   // and whenever the FSM is outside IDLE; flush blocks acceptance.
   assign req_ready = ready_reg & ~flush;
   assign accept    = req_valid & req_ready;

   // Parallel tag compare across all lines.
   generate
      for (genvar gi = 0; gi < LINES; gi++) begin : g_cmp
         assign hit_vec[gi] = valid_reg[gi] && (tag_arr[gi] == req_tag);
      end
   endgenerate

   assign any_hit = |hit_vec;

   // At most one line can match because refills only happen on a miss.
   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < LINES; i++) begin
         if (hit_vec[i]) begin
            hit_idx = IDX_W'(i);
         end
      end
   end

   // DATA_W is fixed at 32, so word k starts at bit {k, 5'b0}.
   assign hit_line = data_arr[hit_idx];
   assign hit_word = hit_line[{req_off, 5'd0} +: DATA_W];

   fa_cache_victim_sel #(
      .LINES (LINES)
   ) u_victim_sel (
      .valid         (valid_reg),
      .ptr           (ptr_reg),
      .victim        (victim_idx),
      .replace_valid (victim_repl)
   );

   // Tag/data storage: no reset; validity is tracked by valid_reg.
   always_ff @(posedge clk) begin
      if (state_reg == REFILL && mem_resp_valid) begin
         data_arr[victim_reg][{beat_reg, 5'd0} +: DATA_W] <= mem_resp_data;
         if (beat_reg == LAST_BEAT) begin
            tag_arr[victim_reg] <= tag_reg;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         valid_reg     <= '0;
         ptr_reg       <= '0;
         victim_reg    <= '0;
         repl_reg      <= 1'b0;
         beat_reg      <= '0;
         off_reg       <= '0;
         tag_reg       <= '0;
         word_reg      <= '0;
         ready_reg     <= 1'b0;
         resp_valid    <= 1'b0;
         resp_hit      <= 1'b0;
         resp_data     <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               ready_reg <= 1'b1;
               if (flush) begin
                  valid_reg <= '0;
                  ptr_reg   <= '0;
               end else if (accept) begin
                  ready_reg <= 1'b0;
                  off_reg   <= req_off;
                  tag_reg   <= req_tag;
                  if (any_hit) begin
                     state_reg  <= HIT_RESP;
                     resp_valid <= 1'b1;
                     resp_hit   <= 1'b1;
                     resp_data  <= hit_word;
                  end else begin
                     state_reg     <= MISS_REQ;
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= {req_tag, {(OFF_W + 2){1'b0}}};
                     victim_reg    <= victim_idx;
                     repl_reg      <= victim_repl;
                  end
               end
            end

            HIT_RESP: begin
               resp_valid <= 1'b0;
               resp_hit   <= 1'b0;
               resp_data  <= '0;
               ready_reg  <= 1'b1;
               state_reg  <= IDLE;
            end

            MISS_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  beat_reg      <= '0;
                  state_reg     <= REFILL;
               end
            end

            REFILL: begin
               if (mem_resp_valid) begin
                  if (beat_reg == off_reg) begin
                     word_reg <= mem_resp_data;
                  end
                  if (beat_reg == LAST_BEAT) begin
                     valid_reg[victim_reg] <= 1'b1;
                     if (repl_reg) begin
                        ptr_reg <= ptr_reg + 1'b1;
                     end
                     beat_reg   <= '0;
                     state_reg  <= MISS_RESP;
                     resp_valid <= 1'b1;
                     resp_hit   <= 1'b0;
                     // The requested word may be the beat arriving right now.
                     resp_data  <= (off_reg == LAST_BEAT) ? mem_resp_data : word_reg;
                  end else begin
                     beat_reg <= beat_reg + 1'b1;
                  end
               end
            end

            MISS_RESP: begin
               resp_valid <= 1'b0;
               resp_data  <= '0;
               ready_reg  <= 1'b1;
               state_reg  <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fully_assoc_cache_ctrl.sv
// Directed self-checking bench for fully_assoc_cache_ctrl.
// Drives requests and acts as the refill memory through the interface bundle.
module tb_fully_assoc_cache_ctrl;
   logic clk;
   logic rst_n;
   logic flush;
   int   n_cmp;
   int   n_bad;

   fully_assoc_cache_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   fully_assoc_cache_ctrl #(
      .ADDR_W (16),
      .DATA_W (32),
      .LINES  (16),
      .WORDS  (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .req_valid      (bus.req_valid),
      .req_ready      (bus.req_ready),
      .req_addr       (bus.req_addr),
      .resp_valid     (bus.resp_valid),
      .resp_hit       (bus.resp_hit),
      .resp_data      (bus.resp_data),
      .mem_req_valid  (bus.mem_req_valid),
      .mem_req_ready  (bus.mem_req_ready),
      .mem_req_addr   (bus.mem_req_addr),
      .mem_resp_valid (bus.mem_resp_valid),
      .mem_resp_data  (bus.mem_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One lookup transaction. On a miss the bench plays memory: it holds
   // mem_req_ready low for req_stall cycles and inserts gap idle cycles
   // before every refill beat; beat k carries base + k.
   task automatic access(input logic [15:0] addr, input bit exp_hit,
                         input logic [31:0] exp_data, input logic [31:0] base,
                         input int req_stall, input int gap);
      logic [15:0] line;
      line = {addr[15:4], 4'h0};
      @(negedge clk);
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (exp_hit) begin
         check("hit_resp_valid", 32'(bus.resp_valid), 32'd1);
         check("hit_resp_hit", 32'(bus.resp_hit), 32'd1);
         check("hit_resp_data", bus.resp_data, exp_data);
         check("hit_no_mem_req", 32'(bus.mem_req_valid), 32'd0);
         @(negedge clk);
         check("hit_resp_drop", 32'(bus.resp_valid), 32'd0);
         check("hit_data_zero", bus.resp_data, 32'd0);
      end else begin
         check("miss_no_resp", 32'(bus.resp_valid), 32'd0);
         check("miss_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
         check("miss_mem_req_addr", 32'(bus.mem_req_addr), 32'(line));
         for (int s = 0; s < req_stall; s++) begin
            @(negedge clk);
            check("stall_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
            check("stall_mem_req_addr", 32'(bus.mem_req_addr), 32'(line));
         end
         bus.mem_req_ready = 1'b1;
         @(negedge clk);
         bus.mem_req_ready = 1'b0;
         check("mem_req_dropped", 32'(bus.mem_req_valid), 32'd0);
         for (int k = 0; k < 4; k++) begin
            repeat (gap) @(negedge clk);
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = base + 32'(k);
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = 32'd0;
         end
         check("miss_resp_valid", 32'(bus.resp_valid), 32'd1);
         check("miss_resp_hit", 32'(bus.resp_hit), 32'd0);
         check("miss_resp_data", bus.resp_data, exp_data);
         @(negedge clk);
         check("miss_resp_drop", 32'(bus.resp_valid), 32'd0);
         check("miss_data_zero", bus.resp_data, 32'd0);
      end
      $display("access addr=0x%04h expect_hit=%0d expect_data=0x%08h", addr, exp_hit, exp_data);
   endtask

   // Line i of the fill sweep lives at 0x2000 + 16*i; word (i%4) is requested.
   task automatic access_t(input int i, input bit exp_hit);
      logic [15:0] a;
      logic [31:0] b;
      a = 16'(32'h2000 + i * 16 + (i % 4) * 4);
      b = 32'hC500_0000 + 32'h2000 + 32'(i * 16);
      access(a, exp_hit, b + 32'(i % 4), b, 0, 0);
   endtask

   initial begin
      n_cmp              = 0;
      n_bad              = 0;
      rst_n              = 1'b0;
      flush              = 1'b0;
      bus.req_valid      = 1'b0;
      bus.req_addr       = '0;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      check("rst_mem_req_addr", 32'(bus.mem_req_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Cold miss, then hits within the same line
      access(16'h1234, 1'b0, 32'h0000_00A1, 32'h0000_00A0, 0, 0);
      access(16'h1238, 1'b1, 32'h0000_00A2, 32'h0, 0, 0);
      access(16'h123C, 1'b1, 32'h0000_00A3, 32'h0, 0, 0);

      // Flush together with a request: request refused, cache emptied
      @(negedge clk);
      flush         = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_addr  = 16'h1234;
      #1;
      check("flush_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      flush         = 1'b0;
      bus.req_valid = 1'b0;
      check("flush_no_resp", 32'(bus.resp_valid), 32'd0);
      check("flush_no_mem_req", 32'(bus.mem_req_valid), 32'd0);

      // Post-flush miss with a stalled fetch and gaps between beats
      access(16'h1234, 1'b0, 32'h0000_00D1, 32'h0000_00D0, 5, 2);
      access(16'h1230, 1'b1, 32'h0000_00D0, 32'h0, 0, 0);

      // Fill every line, then exercise round-robin replacement
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      for (int i = 0; i < 16; i++) access_t(i, 1'b0);
      access_t(16, 1'b0);   // all valid: replaces line 0, pointer -> 1
      access_t(1, 1'b1);
      access_t(15, 1'b1);
      access_t(16, 1'b1);
      access_t(17, 1'b0);   // replaces line 1, pointer -> 2
      access_t(2, 1'b1);
      access_t(17, 1'b1);
      access_t(1, 1'b0);    // line 1 was evicted
      access_t(0, 1'b0);    // line 0 was evicted

      // Reset in the middle of a refill
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = 16'h5674;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("pre_rst_mem_req_addr", 32'(bus.mem_req_addr), 32'h0000_5670);
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h0000_00E0;
      @(negedge clk);
      bus.mem_resp_data  = 32'h0000_00E1;
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("mid_rst_resp_hit", 32'(bus.resp_hit), 32'd0);
      check("mid_rst_resp_data", bus.resp_data, 32'd0);
      check("mid_rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      check("mid_rst_mem_req_addr", 32'(bus.mem_req_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // Stray beats from the abandoned fill
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 32'h0000_00EE;
      repeat (2) @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      check("stray_no_resp", 32'(bus.resp_valid), 32'd0);
      access(16'h5674, 1'b0, 32'h0000_00F1, 32'h0000_00F0, 0, 1);
      access(16'h1234, 1'b0, 32'h0000_0091, 32'h0000_0090, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
